// File: rtl/lsu_dcache_port_pkg.sv
// Shared types for the LSU data-cache port.
// Contents: datapath/port widths, access-size codes, FSM state codes, the latched
// request-control struct, and a size->byte-count helper used by the lane aligner.
package lsu_dcache_port_pkg;

    localparam int LSU_XLEN = 64;
    localparam int LSU_AW   = 8;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic      we;
        lsu_size_e size;
        logic      uns;
    } lsu_ctl_t;

    // Number of bytes touched by an access of the given size.
    function automatic int unsigned lsu_bytes(input lsu_size_e s);
        return 32'd1 << s;
    endfunction

endpackage

// File: rtl/lsu_dcache_port_lane_align.sv
// lsu_lane_align: combinational byte-lane steering between a memory word and
// right-justified CPU data. Shared with the fetch side.
// Ports:
//   size, off, uns  access size, byte offset within the word, zero-extend select
//   rd              word read from memory
//   wd              right-justified store data
//   ld_data         extracted, extended load result
//   st_data         rd with the addressed lanes replaced by wd
module lsu_lane_align
    import lsu_dcache_port_pkg::*;
#(
    parameter int XLEN = LSU_XLEN
) (
    input  lsu_size_e                 size,
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  logic                      uns,
    input  logic [XLEN-1:0]           rd,
    input  logic [XLEN-1:0]           wd,
    output logic [XLEN-1:0]           ld_data,
    output logic [XLEN-1:0]           st_data
);
    localparam int NB = XLEN / 8;

    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] wsh;
    logic [NB-1:0]   bmask;
    logic            sx;

    always_comb begin
        // Little-endian: byte k lives in bits 8k+7:8k, so the offset is a plain shift.
        sh      = rd >> {off, 3'b000};
        wsh     = wd << {off, 3'b000};
        bmask   = NB'((1 << lsu_bytes(size)) - 1) << off;
        sx      = ~uns;
        ld_data = sh;
        case (size)
            SIZE_B:  ld_data = {{(XLEN-8){sh[7] & sx}},   sh[7:0]};
            SIZE_H:  ld_data = {{(XLEN-16){sh[15] & sx}}, sh[15:0]};
            SIZE_W:  ld_data = {{(XLEN-32){sh[31] & sx}}, sh[31:0]};
            default: ld_data = sh;
        endcase
        st_data = rd;
        for (int k = 0; k < NB; k++) begin
            if (bmask[k]) st_data[8*k +: 8] = wsh[8*k +: 8];
        end
    end

endmodule

// File: rtl/lsu_dcache_port.sv
// lsu_dcache_port: single-outstanding load/store initiator for a word-wide memory
// port (comb read, sync write). Sub-word stores do read-modify-write over two cycles.
// Ports:
//   clk, reset                         clock, async active-high reset
//   req_valid/ready/we/size/unsigned   request handshake and control
//   req_addr, req_wdata                byte address, right-justified store data
//   resp_valid/ready                   response handshake
//   resp_rdata, resp_misalign          load result / misalignment flag
//   mem_a, mem_we, mem_wd, mem_rd      memory word index, write strobe/data, read data
module lsu_dcache_port
    import lsu_dcache_port_pkg::*;
#(
    parameter int XLEN = LSU_XLEN,
    parameter int AW   = LSU_AW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_misalign,
    output logic [AW-1:0]   mem_a,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_wd,
    input  logic [XLEN-1:0] mem_rd
);
    localparam int OFFW = $clog2(XLEN/8);

    lsu_state_e      state;
    lsu_ctl_t        ctl_q;
    logic [OFFW-1:0] off_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] merge_q;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] st_data;
    logic            req_mis;
    logic            store_d;
    logic            unused_addr_hi;

    // Address bits above the word index alias onto the same memory.
    assign unused_addr_hi = ^req_addr[XLEN-1:AW+OFFW];

    assign req_mis = |(req_addr[OFFW-1:0] & OFFW'((1 << req_size) - 1));
    assign store_d = (state == ST_ACCESS) && ctl_q.we && (ctl_q.size == SIZE_D);

    // Write strobe is decoded from state so an async reset kills it immediately.
    assign mem_we = (state == ST_WRITE) || store_d;

    always_comb begin
        mem_wd = '0;
        if (state == ST_WRITE) mem_wd = merge_q;
        else if (store_d)      mem_wd = wdata_q;
    end

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .size    (ctl_q.size),
        .off     (off_q),
        .uns     (ctl_q.uns),
        .rd      (mem_rd),
        .wd      (wdata_q),
        .ld_data (ld_data),
        .st_data (st_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            ctl_q         <= '0;
            off_q         <= '0;
            wdata_q       <= '0;
            merge_q       <= '0;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_misalign <= 1'b0;
            mem_a         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        ctl_q      <= '{we: req_we, size: lsu_size_e'(req_size), uns: req_unsigned};
                        off_q      <= req_addr[OFFW-1:0];
                        wdata_q    <= req_wdata;
                        req_ready  <= 1'b0;
                        resp_rdata <= '0;
                        if (req_mis) begin
                            // No memory access; mem_a keeps its previous index.
                            resp_misalign <= 1'b1;
                            resp_valid    <= 1'b1;
                            state         <= ST_RESP;
                        end else begin
                            resp_misalign <= 1'b0;
                            mem_a         <= req_addr[AW+OFFW-1:OFFW];
                            state         <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!ctl_q.we) begin
                        resp_rdata <= ld_data;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end else if (ctl_q.size == SIZE_D) begin
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        merge_q <= st_data;
                        state   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dcache_port.sv
module tb_lsu_dcache_port;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_misalign;
    logic [7:0]  mem_a;
    logic        mem_we;
    logic [63:0] mem_wd;
    logic [63:0] mem_rd;

    logic [63:0] mem     [256];
    logic [63:0] ref_mem [256];
    int          we_cnt = 0;
    logic [7:0]  last_wa = '0;
    int          errors = 0;
    int          checks = 0;

    lsu_dcache_port dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_misalign(resp_misalign), .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // Memory: combinational read, synchronous write.
    assign mem_rd = mem[mem_a];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_a] <= mem_wd;
            we_cnt++;
            last_wa = mem_a;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte-level reference: addresses are byte arrays within 256 aliased 8-byte words.
    function automatic void ref_op(input logic we, input logic [1:0] size, input logic uns,
                                   input logic [63:0] addr, input logic [63:0] wdata,
                                   output logic [63:0] rdata, output logic mis, output int lat);
        int nb  = 1 << size;
        int idx = int'((addr >> 3) & 64'hFF);
        int off = int'(addr & 64'h7);
        rdata = '0;
        mis   = (addr % nb) != 0;
        if (mis) begin
            lat = 1;
            return;
        end
        if (!we) begin
            for (int b = 0; b < nb; b++)
                rdata = rdata | (64'(ref_mem[idx][8*(off+b) +: 8]) << (8*b));
            if (!uns && nb < 8 && rdata[8*nb-1]) rdata = rdata | (~64'd0 << (8*nb));
            lat = 2;
        end else begin
            for (int b = 0; b < nb; b++) ref_mem[idx][8*(off+b) +: 8] = wdata[8*b +: 8];
            lat = (nb == 8) ? 2 : 3;
        end
    endfunction

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          output logic [63:0] rdata, output logic mis, output int lat,
                          output int wcnt, output logic [7:0] wa);
        @(negedge clk);
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        we_cnt = 0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
        end
        if (!resp_valid) chk("resp_timeout", 64'd0, 64'd1);
        rdata = resp_rdata;
        mis   = resp_misalign;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        wcnt = we_cnt;
        wa   = last_wa;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        mis;
        int          lat;
        int          wcnt;
        logic [7:0]  wa;
    } vec_t;

    vec_t        tbl [14];
    logic [63:0] rd, erd, old, held;
    logic        ms, ems;
    int          lt, elt, wc, to;
    logic [7:0]  wa;

    initial begin
        tbl[0]  = '{1'b0, 2'd0, 1'b1, 64'h3,   64'h0,                  64'h44,                 1'b0, 2, 0, 8'h00};
        tbl[1]  = '{1'b0, 2'd0, 1'b0, 64'h7,   64'h0,                  64'hFFFFFFFFFFFFFF88,   1'b0, 2, 0, 8'h00};
        tbl[2]  = '{1'b0, 2'd2, 1'b0, 64'h4,   64'h0,                  64'hFFFFFFFF88776655,   1'b0, 2, 0, 8'h00};
        tbl[3]  = '{1'b0, 2'd1, 1'b0, 64'h6,   64'h0,                  64'hFFFFFFFFFFFF8877,   1'b0, 2, 0, 8'h00};
        tbl[4]  = '{1'b0, 2'd1, 1'b0, 64'h2,   64'h0,                  64'h4433,               1'b0, 2, 0, 8'h00};
        tbl[5]  = '{1'b1, 2'd1, 1'b0, 64'h0A,  64'hBEEF,               64'h0,                  1'b0, 3, 1, 8'h01};
        tbl[6]  = '{1'b0, 2'd3, 1'b0, 64'h8,   64'h0,                  64'h00000000BEEF0000,   1'b0, 2, 0, 8'h00};
        tbl[7]  = '{1'b0, 2'd2, 1'b0, 64'h5,   64'h0,                  64'h0,                  1'b1, 1, 0, 8'h00};
        tbl[8]  = '{1'b1, 2'd3, 1'b0, 64'h7F8, 64'h0123456789ABCDEF,   64'h0,                  1'b0, 2, 1, 8'hFF};
        tbl[9]  = '{1'b0, 2'd3, 1'b0, 64'h7F8, 64'h0,                  64'h0123456789ABCDEF,   1'b0, 2, 0, 8'h00};
        tbl[10] = '{1'b0, 2'd3, 1'b0, 64'h800, 64'h0,                  64'h8877665544332211,   1'b0, 2, 0, 8'h00};
        tbl[11] = '{1'b1, 2'd0, 1'b0, 64'h9,   64'hFFFFFFFFFFFFFF5A,   64'h0,                  1'b0, 3, 1, 8'h01};
        tbl[12] = '{1'b0, 2'd2, 1'b1, 64'h8,   64'h0,                  64'h00000000BEEF5A00,   1'b0, 2, 0, 8'h00};
        tbl[13] = '{1'b1, 2'd3, 1'b0, 64'h804, 64'h1234,               64'h0,                  1'b1, 1, 0, 8'h00};

        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        mem[0] = 64'h8877665544332211;
        mem[1] = 64'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_misalign", {63'd0, resp_misalign}, 64'd0);
        chk("rst_mem_a", {56'd0, mem_a}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_mem_wd", mem_wd, 64'd0);
        @(negedge clk) reset = 1'b0;

        // Directed vectors
        for (int i = 0; i < 14; i++) begin
            do_req(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, rd, ms, lt, wc, wa);
            ref_op(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, erd, ems, elt);
            chk($sformatf("v%0d_rdata", i), rd, tbl[i].rdata);
            chk($sformatf("v%0d_misalign", i), {63'd0, ms}, {63'd0, tbl[i].mis});
            chk($sformatf("v%0d_latency", i), 64'(lt), 64'(tbl[i].lat));
            chk($sformatf("v%0d_write_cycles", i), 64'(wc), 64'(tbl[i].wcnt));
            if (tbl[i].wcnt > 0) chk($sformatf("v%0d_write_index", i), {56'd0, wa}, {56'd0, tbl[i].wa});
        end
        chk("word1_image", mem[1], 64'h00000000BEEF5A00);
        chk("wordFF_image", mem[255], 64'h0123456789ABCDEF);
        chk("word0_image", mem[0], 64'h8877665544332211);

        // Response backpressure: outputs hold, new requests ignored.
        ref_op(1'b0, 2'd3, 1'b0, 64'h8, 64'h0, erd, ems, elt);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_addr = 64'h8;
        @(posedge clk);
        #1 req_valid = 1'b0;
        to = 0;
        while (!resp_valid && to < 20) begin @(negedge clk); to++; end
        chk("bp_resp_valid", {63'd0, resp_valid}, 64'd1);
        held = resp_rdata;
        chk("bp_rdata", held, erd);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid = c[0]; req_we = 1'b1; req_addr = 64'h10 + 64'(c);
            chk($sformatf("bp%0d_resp_valid", c), {63'd0, resp_valid}, 64'd1);
            chk($sformatf("bp%0d_rdata", c), resp_rdata, held);
            chk($sformatf("bp%0d_req_ready", c), {63'd0, req_ready}, 64'd0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk("bp_no_write", 64'(mem[2]), 64'(ref_mem[2]));

        // Reset during the WRITE cycle of a byte store.
        old = mem[2];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 64'h11; req_wdata = 64'hAA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 chk("rw_we_in_write", {63'd0, mem_we}, 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("rw_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rw_mem_wd", mem_wd, 64'd0);
        chk("rw_mem_a", {56'd0, mem_a}, 64'd0);
        chk("rw_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rw_resp_valid", {63'd0, resp_valid}, 64'd0);
        @(posedge clk);
        #1 chk("rw_word_kept", mem[2], old);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        chk("rw_no_resp", {63'd0, resp_valid}, 64'd0);

        // Random traffic against the byte-level model.
        for (int n = 0; n < 300; n++) begin
            logic        rwe, runs;
            logic [1:0]  rsz;
            logic [63:0] raddr, rwd;
            rwe   = 1'($urandom % 2);
            rsz   = 2'($urandom % 4);
            runs  = 1'($urandom % 2);
            raddr = 64'($urandom_range(0, 4095));
            if ($urandom % 4 != 0) raddr = raddr & ~((64'd1 << rsz) - 64'd1);
            rwd   = {$urandom, $urandom};
            do_req(rwe, rsz, runs, raddr, rwd, rd, ms, lt, wc, wa);
            ref_op(rwe, rsz, runs, raddr, rwd, erd, ems, elt);
            chk($sformatf("r%0d_rdata", n), rd, erd);
            chk($sformatf("r%0d_misalign", n), {63'd0, ms}, {63'd0, ems});
            chk($sformatf("r%0d_latency", n), 64'(lt), 64'(elt));
            chk($sformatf("r%0d_write_cycles", n), 64'(wc), (rwe && !ems) ? 64'd1 : 64'd0);
            if (wc > 0) chk($sformatf("r%0d_write_index", n), {56'd0, wa}, (raddr >> 3) & 64'hFF);
        end
        begin
            int diffs = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
            chk("final_mem_image_diffs", 64'(diffs), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
